// File: rtl/crc32_arb_if.sv
// Signal bundle between crc32_arb, its two CRC requesters and the shared crc32_core.
// The arbiter connects through the slave modport; the requester/core side uses master.
interface crc32_arb_if #(
  parameter int DATA_WD = 32,
  parameter int NUM_WD  = 2
);
  logic [1:0]         req_i;
  logic [1:0]         val_i;
  logic [DATA_WD-1:0] dat0_i;
  logic [DATA_WD-1:0] dat1_i;
  logic [NUM_WD-1:0]  num0_i;
  logic [NUM_WD-1:0]  num1_i;
  logic [1:0]         lst_i;
  logic [1:0]         gnt_o;
  logic [1:0]         ack_o;
  logic [1:0]         done_o;
  logic [DATA_WD-1:0] crc_o;
  logic               core_start_o;
  logic               core_val_o;
  logic [DATA_WD-1:0] core_dat_o;
  logic [NUM_WD-1:0]  core_num_o;
  logic               core_lst_o;
  logic               core_ack_i;
  logic               core_done_i;
  logic [DATA_WD-1:0] core_dat_i;

  modport slave (
    input  req_i, val_i, dat0_i, dat1_i, num0_i, num1_i, lst_i,
    input  core_ack_i, core_done_i, core_dat_i,
    output gnt_o, ack_o, done_o, crc_o,
    output core_start_o, core_val_o, core_dat_o, core_num_o, core_lst_o
  );

  modport master (
    output req_i, val_i, dat0_i, dat1_i, num0_i, num1_i, lst_i,
    output core_ack_i, core_done_i, core_dat_i,
    input  gnt_o, ack_o, done_o, crc_o,
    input  core_start_o, core_val_o, core_dat_o, core_num_o, core_lst_o
  );
endinterface

// File: rtl/crc32_arb.sv
// Round-robin arbiter sharing one crc32_core between two requesters; a grant spans
// one whole CRC computation, from the core start pulse to the core done pulse.
module crc32_arb #(
  parameter int DATA_WD = 32,
  parameter int NUM_WD  = 2
) (
  input logic        clk,
  input logic        rst,
  crc32_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t             state_r;
  logic               sel_r;
  logic               prio_r;
  logic [1:0]         gnt_r;
  logic               start_r;

  logic               win_s;
  logic               own_val_s;
  logic               own_lst_s;
  logic [DATA_WD-1:0] own_dat_s;
  logic [NUM_WD-1:0]  own_num_s;
  logic [1:0]         own_ack_s;

  // Pick the next owner: a lone request wins outright, a tie goes to prio.
  always_comb begin
    win_s = 1'b0;
    if (bus.req_i == 2'b11) begin
      win_s = prio_r;
    end else begin
      win_s = bus.req_i[1];
    end
  end

  // Owner word mux; the non-owner's inputs never reach the core.
  always_comb begin
    own_val_s = 1'b0;
    own_lst_s = 1'b0;
    own_dat_s = {DATA_WD{1'b0}};
    own_num_s = {NUM_WD{1'b0}};
    if (sel_r) begin
      own_val_s = bus.val_i[1];
      own_lst_s = bus.lst_i[1];
      own_dat_s = bus.dat1_i;
      own_num_s = bus.num1_i;
    end else begin
      own_val_s = bus.val_i[0];
      own_lst_s = bus.lst_i[0];
      own_dat_s = bus.dat0_i;
      own_num_s = bus.num0_i;
    end
    own_ack_s = sel_r ? {bus.core_ack_i, 1'b0} : {1'b0, bus.core_ack_i};
  end

  // Sequencer: state, owner, round-robin pointer and the registered grant/start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sel_r   <= 1'b0;
      prio_r  <= 1'b0;
      gnt_r   <= 2'b00;
      start_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|bus.req_i) begin
            sel_r   <= win_s;
            gnt_r   <= win_s ? 2'b10 : 2'b01;
            start_r <= 1'b1;
            state_r <= START;
          end
        end
        START: begin
          start_r <= 1'b0;
          state_r <= XFER;
        end
        XFER: begin
          if (own_val_s && own_lst_s) begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          // Pointer favours the other requester once this computation completes.
          if (bus.core_done_i) begin
            prio_r  <= ~sel_r;
            gnt_r   <= 2'b00;
            state_r <= IDLE;
          end
        end
        default: begin
          gnt_r   <= 2'b00;
          start_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_o        = gnt_r;
  assign bus.core_start_o = start_r;

  // Zero-latency word path, ack routing and CRC pass-through, gated by state.
  always_comb begin
    bus.core_val_o = 1'b0;
    bus.core_dat_o = {DATA_WD{1'b0}};
    bus.core_num_o = {NUM_WD{1'b0}};
    bus.core_lst_o = 1'b0;
    bus.ack_o      = 2'b00;
    bus.done_o     = 2'b00;
    bus.crc_o      = {DATA_WD{1'b0}};
    case (state_r)
      XFER: begin
        bus.core_val_o = own_val_s;
        bus.core_dat_o = own_dat_s;
        bus.core_num_o = own_num_s;
        bus.core_lst_o = own_lst_s;
        bus.ack_o      = own_ack_s;
      end
      WAIT: begin
        bus.ack_o = own_ack_s;
        if (bus.core_done_i) begin
          bus.done_o = sel_r ? 2'b10 : 2'b01;
          bus.crc_o  = bus.core_dat_i;
        end else begin
          bus.done_o = 2'b00;
          bus.crc_o  = {DATA_WD{1'b0}};
        end
      end
      default: begin
        bus.ack_o  = 2'b00;
        bus.done_o = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_crc32_arb.sv
// Randomized bench for crc32_arb: behavioural core model, transaction-level arbiter
// reference and a CRC-32 reference computed directly from the requested byte streams.
module tb_crc32_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc32_arb_if #(.DATA_WD(32), .NUM_WD(2)) bus ();
  crc32_arb #(.DATA_WD(32), .NUM_WD(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fin = 0;
  int start_cnt = 0;
  logic [31:0] s_dat [2][16];
  logic [1:0]  s_num [2][16];
  int          s_len [2];
  logic [31:0] exp_crc [2];
  int gnt_wait [2];
  int gnt_cyc [2];
  int done_cyc [2];
  int ord [2];
  bit noise_on = 1'b0;
  bit spur_ack = 1'b0;
  bit spur_done = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reflected CRC-32 (poly 0xEDB88320), as used by PNG.
  function automatic logic [31:0] crc_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int id, input logic [7:0] q[$]);
    int n;
    int w;
    logic [31:0] d;
    int k;
    n = q.size();
    w = 0;
    exp_crc[id] = crc_of(q);
    for (int p = 0; p < n; p += 4) begin
      d = $urandom;
      k = (n - p > 4) ? 4 : n - p;
      for (int j = 0; j < k; j++) d[31-8*j -: 8] = q[p+j];
      s_dat[id][w] = d;
      s_num[id][w] = 2'(k - 1);
      w++;
    end
    s_len[id] = w;
  endtask

  task automatic rand_bytes(output logic [7:0] q[$]);
    int n;
    q = {};
    n = $urandom_range(1, 24);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic drive_word(input int id, input logic v, input logic [31:0] d,
                            input logic [1:0] n, input logic l);
    bus.val_i[id] = v;
    bus.lst_i[id] = l;
    if (id == 0) begin
      bus.dat0_i = d;
      bus.num0_i = n;
    end else begin
      bus.dat1_i = d;
      bus.num1_i = n;
    end
  endtask

  // One requester transaction: request, wait grant, send words one per ack, wait done.
  task automatic run_req(input int id, input int gap_max);
    int n;
    bit got;
    logic [31:0] crc;
    @(posedge clk); #1;
    bus.req_i[id] = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      @(negedge clk);
      n++;
      if (bus.gnt_o[id]) got = 1'b1;
    end
    if (!got) begin
      chk_eq("gnt_timeout", 64'(0), 64'(1));
      bus.req_i[id] = 1'b0;
      return;
    end
    gnt_wait[id] = n - 1;
    gnt_cyc[id] = cyc;
    for (int w = 0; w < s_len[id]; w++) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      @(posedge clk); #1;
      drive_word(id, 1'b1, s_dat[id][w], s_num[id][w], (w == s_len[id] - 1));
      @(posedge clk); #1;
      drive_word(id, 1'b0, $urandom, 2'b00, 1'b0);
      n = 0;
      got = 1'b0;
      while (n < 50 && !got) begin
        @(negedge clk);
        n++;
        if (bus.ack_o[id]) got = 1'b1;
      end
      if (!got) chk_eq("ack_timeout", 64'(0), 64'(1));
    end
    n = 0;
    got = 1'b0;
    crc = 32'd0;
    while (n < 50 && !got) begin
      @(negedge clk);
      n++;
      if (bus.done_o[id]) begin
        got = 1'b1;
        crc = bus.crc_o;
        done_cyc[id] = cyc;
      end
    end
    if (!got) chk_eq("done_timeout", 64'(0), 64'(1));
    chk_eq(id == 0 ? "crc_req0" : "crc_req1", 64'(crc), 64'(exp_crc[id]));
    fin++;
    ord[id] = fin;
    @(posedge clk); #1;
    bus.req_i[id] = 1'b0;
    @(negedge clk);
    chk_eq("gnt_clear", 64'(bus.gnt_o), 64'(0));
  endtask

  task automatic noise(input int id);
    while (noise_on) begin
      @(posedge clk); #1;
      drive_word(id, 1'($urandom), $urandom, 2'($urandom), 1'($urandom));
    end
    drive_word(id, 1'b0, 32'd0, 2'b00, 1'b0);
  endtask

  // Behavioural crc32_core: ack the cycle after a word, CRC ready three cycles later.
  task automatic core_model();
    logic [7:0] cq[$];
    int dcnt;
    logic sv, sl, sst, srst;
    logic [31:0] sd;
    logic [1:0] sn;
    dcnt = 0;
    forever begin
      @(negedge clk);
      sv = bus.core_val_o;
      sd = bus.core_dat_o;
      sn = bus.core_num_o;
      sl = bus.core_lst_o;
      sst = bus.core_start_o;
      srst = rst;
      @(posedge clk); #1;
      cyc++;
      bus.core_ack_i = 1'b0;
      bus.core_done_i = 1'b0;
      bus.core_dat_i = $urandom;
      if (srst) begin
        cq.delete();
        dcnt = 0;
      end else begin
        if (sst) begin
          cq.delete();
          dcnt = 0;
        end
        if (sv) begin
          for (int j = 0; j <= int'(sn); j++) cq.push_back(sd[31-8*j -: 8]);
          bus.core_ack_i = 1'b1;
          if (sl) dcnt = 3;
        end else if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            bus.core_done_i = 1'b1;
            bus.core_dat_i = crc_of(cq);
          end
        end
      end
      if (spur_ack) begin
        bus.core_ack_i = 1'b1;
        spur_ack = 1'b0;
      end
      if (spur_done) begin
        bus.core_done_i = 1'b1;
        spur_done = 1'b0;
      end
    end
  endtask

  // Transaction-level reference: who owns the core and which phase of its job it is in.
  task automatic monitor();
    int own;
    bit started, lsent, prio;
    logic [1:0] e_ack;
    own = -1;
    started = 1'b0;
    lsent = 1'b0;
    prio = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.core_start_o) start_cnt++;
      chk_eq("gnt", 64'(bus.gnt_o), 64'(own < 0 ? 2'b00 : (own == 1 ? 2'b10 : 2'b01)));
      chk_eq("start", 64'(bus.core_start_o), 64'(own >= 0 && !started));
      chk_eq("done_overlap", 64'(bus.done_o == 2'b11), 64'(0));
      e_ack = 2'b00;
      if (own >= 0 && started) e_ack = (own == 1) ? {bus.core_ack_i, 1'b0} : {1'b0, bus.core_ack_i};
      chk_eq("ack", 64'(bus.ack_o), 64'(e_ack));
      if (own >= 0 && started && !lsent) begin
        chk_eq("core_val", 64'(bus.core_val_o), 64'(bus.val_i[own]));
        if (bus.val_i[own]) begin
          chk_eq("core_dat", 64'(bus.core_dat_o), 64'(own == 1 ? bus.dat1_i : bus.dat0_i));
          chk_eq("core_num", 64'(bus.core_num_o), 64'(own == 1 ? bus.num1_i : bus.num0_i));
          chk_eq("core_lst", 64'(bus.core_lst_o), 64'(bus.lst_i[own]));
        end
      end else begin
        chk_eq("core_val_idle", 64'(bus.core_val_o), 64'(0));
      end
      if (own >= 0 && lsent && bus.core_done_i) begin
        chk_eq("done", 64'(bus.done_o), 64'(own == 1 ? 2'b10 : 2'b01));
        chk_eq("crc_pass", 64'(bus.crc_o), 64'(bus.core_dat_i));
      end else begin
        chk_eq("done_none", 64'(bus.done_o), 64'(0));
      end
      if (rst) begin
        own = -1;
        started = 1'b0;
        lsent = 1'b0;
        prio = 1'b0;
      end else if (own < 0) begin
        if (bus.req_i != 2'b00) begin
          own = (bus.req_i == 2'b11) ? int'(prio) : (bus.req_i[1] ? 1 : 0);
          started = 1'b0;
          lsent = 1'b0;
        end
      end else if (!started) begin
        started = 1'b1;
      end else if (!lsent) begin
        if (bus.val_i[own] && bus.lst_i[own]) lsent = 1'b1;
      end else if (bus.core_done_i) begin
        prio = (own == 0);
        own = -1;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq(tag, 64'({bus.gnt_o, bus.ack_o, bus.done_o, bus.core_start_o, bus.core_val_o,
                     bus.core_num_o, bus.core_lst_o}), 64'(0));
    chk_eq(tag, 64'({bus.crc_o, bus.core_dat_o}), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int sc;
    int mode;
    int tb_prio;
    rst = 1'b1;
    bus.req_i = 2'b00;
    drive_word(0, 1'b0, 32'd0, 2'b00, 1'b0);
    drive_word(1, 1'b0, 32'd0, 2'b00, 1'b0);
    bus.core_ack_i = 1'b0;
    bus.core_done_i = 1'b0;
    bus.core_dat_i = 32'd0;
    fork
      core_model();
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_outputs");

    // Solo IHDR chunk from requester 0: "IHDR" + 13-byte payload = 5 words, last num 0.
    q0 = '{8'h49, 8'h48, 8'h44, 8'h52, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
           8'h00, 8'h01, 8'h08, 8'h02, 8'h00, 8'h00, 8'h00};
    build(0, q0);
    chk_eq("ihdr_words", 64'(s_len[0]), 64'(5));
    sc = start_cnt;
    run_req(0, 0);
    chk_eq("gnt_latency", 64'(gnt_wait[0]), 64'(1));
    chk_eq("start_pulses", 64'(start_cnt - sc), 64'(1));

    // Simultaneous requests after reset: req0 first, then req1.
    do_reset();
    rand_bytes(q0); build(0, q0);
    rand_bytes(q1); build(1, q1);
    fin = 0;
    fork
      run_req(0, 1);
      run_req(1, 1);
    join
    chk_eq("order_r0_first", 64'(ord[0]), 64'(1));
    chk_eq("order_r1_second", 64'(ord[1]), 64'(2));

    // req0 served last, so a fresh tie must go to req1.
    rand_bytes(q0); build(0, q0);
    run_req(0, 0);
    rand_bytes(q0); build(0, q0);
    rand_bytes(q1); build(1, q1);
    fin = 0;
    fork
      run_req(0, 1);
      run_req(1, 1);
    join
    chk_eq("flip_r1_first", 64'(ord[1]), 64'(1));
    chk_eq("flip_r0_second", 64'(ord[0]), 64'(2));

    // req0 arrives while req1 is mid-transfer.
    q1 = {};
    for (int i = 0; i < 32; i++) q1.push_back(8'($urandom));
    build(1, q1);
    rand_bytes(q0); build(0, q0);
    fork
      run_req(1, 1);
      begin
        for (int n = 0; n < 100 && !bus.gnt_o[1]; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        run_req(0, 0);
      end
    join
    chk_eq("regrant_gap", 64'(gnt_cyc[0] - done_cyc[1]), 64'(2));

    // Non-owner noise during an IHDR run: CRC must match the solo reference.
    q0 = '{8'h49, 8'h48, 8'h44, 8'h52, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
           8'h00, 8'h01, 8'h08, 8'h02, 8'h00, 8'h00, 8'h00};
    build(0, q0);
    noise_on = 1'b1;
    fork
      begin
        run_req(0, 2);
        noise_on = 1'b0;
      end
      noise(1);
    join

    // Reset during XFER, then a fresh IEND-only stream.
    build(0, q0);
    @(posedge clk); #1;
    bus.req_i[0] = 1'b1;
    for (int n = 0; n < 20 && !bus.gnt_o[0]; n++) @(negedge clk);
    @(posedge clk); #1;
    drive_word(0, 1'b1, s_dat[0][0], s_num[0][0], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_i[0] = 1'b0;
    drive_word(0, 1'b0, 32'd0, 2'b00, 1'b0);
    @(negedge clk);
    chk_all_zero("post_rst_outputs");
    q0 = '{8'h49, 8'h45, 8'h4E, 8'h44};
    build(0, q0);
    exp_crc[0] = 32'hAE42_6082;
    run_req(0, 0);

    // Spurious core ack/done while idle.
    @(negedge clk);
    spur_ack = 1'b1;
    spur_done = 1'b1;
    @(negedge clk);
    chk_eq("spur_done", 64'(bus.done_o), 64'(0));
    chk_eq("spur_ack", 64'(bus.ack_o), 64'(0));
    @(negedge clk);
    chk_eq("spur_idle", 64'({bus.gnt_o, bus.core_start_o}), 64'(0));

    // Random rounds; after IEND from req0 the pointer favours req1.
    tb_prio = 1;
    for (int r = 0; r < 8; r++) begin
      mode = $urandom_range(0, 2);
      rand_bytes(q0); build(0, q0);
      rand_bytes(q1); build(1, q1);
      if (mode == 2) begin
        fin = 0;
        fork
          run_req(0, 2);
          run_req(1, 2);
        join
        chk_eq("rand_winner", 64'(ord[tb_prio]), 64'(1));
      end else begin
        noise_on = 1'b1;
        fork
          begin
            run_req(mode, 2);
            noise_on = 1'b0;
          end
          noise(1 - mode);
        join
        tb_prio = 1 - mode;
      end
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
